uart_tx_fifo: RTL and testbench

- Parametrised UART transmitter with an input FIFO; successor to the fixed single-byte TX path that drives the board's tx_data pin.
- Accepts words over a valid/ready handshake, buffers them, and serialises them as frames: start bit, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits between on-chip result producers (inference output, debug counters) and the FPGA TX pin. Single clock domain.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, range limits and helpers used by the TX path (and later the RX path).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DATA_W_MIN    = 5;
    localparam int DATA_W_MAX    = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Clock cycles per bit, rounded down.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic bit data_w_legal(input int w);
        return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
    endfunction

    function automatic bit stop_bits_legal(input int n);
        return (n >= STOP_BITS_MIN) && (n <= STOP_BITS_MAX);
    endfunction

    function automatic bit depth_legal(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; pointers carry one extra wrap bit so full and empty differ.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (!depth_legal(DEPTH)) begin : g_depth_chk
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage holds data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a valid/ready FIFO; frames are start, DATA_W bits LSB first, optional parity, stop bits.
// Define UART_TX_PARITY_EN to add the parity bit (PARITY_ODD selects odd parity).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int NW  = 4;

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
    end
    if (!data_w_legal(DATA_W)) begin : g_data_w_chk
        $error("uart_tx_fifo: DATA_W must be in 5..9");
    end
    if (!stop_bits_legal(STOP_BITS)) begin : g_stop_chk
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    tx_state_t         state;
    tx_state_t         nxt_state;
    logic [BW-1:0]     baud_cnt;
    logic [BW-1:0]     nxt_baud;
    logic [NW-1:0]     bit_cnt;
    logic [NW-1:0]     nxt_bit;
    logic              baud_last;
    logic              pop;
    logic              shift_en;
    logic              line_bit;
    logic              tx_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd;
    logic [DATA_W-1:0] shreg;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
`endif

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid && s_ready),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign s_ready   = !fifo_full;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign baud_last = (baud_cnt == BW'(DIV - 1));
    assign tx_data   = tx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= nxt_state;
            baud_cnt <= nxt_baud;
            bit_cnt  <= nxt_bit;
            tx_q     <= line_bit;
        end
    end

    // The baud counter only runs inside a bit and restarts at every bit/state boundary.
    always_comb begin
        nxt_state = state;
        nxt_baud  = baud_cnt;
        nxt_bit   = bit_cnt;
        pop       = 1'b0;
        shift_en  = 1'b0;
        line_bit  = 1'b1;
        case (state)
            IDLE: begin
                nxt_baud = '0;
                nxt_bit  = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    nxt_state = START;
                end
            end
            START: begin
                line_bit = 1'b0;
                if (baud_last) begin
                    nxt_baud  = '0;
                    nxt_state = DATA;
                end else begin
                    nxt_baud = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                line_bit = shreg[0];
                if (baud_last) begin
                    nxt_baud = '0;
                    shift_en = 1'b1;
                    if (bit_cnt == NW'(DATA_W - 1)) begin
                        nxt_bit = '0;
`ifdef UART_TX_PARITY_EN
                        nxt_state = PARITY;
`else
                        nxt_state = STOP;
`endif
                    end else begin
                        nxt_bit = bit_cnt + 1'b1;
                    end
                end else begin
                    nxt_baud = baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_bit = par_q;
                if (baud_last) begin
                    nxt_baud  = '0;
                    nxt_state = STOP;
                end else begin
                    nxt_baud = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                line_bit = 1'b1;
                if (baud_last) begin
                    nxt_baud = '0;
                    if (bit_cnt == NW'(STOP_BITS - 1)) begin
                        nxt_bit = '0;
                        // Chain straight into the next start bit when more data is waiting.
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            nxt_state = START;
                        end else begin
                            nxt_state = IDLE;
                        end
                    end else begin
                        nxt_bit = bit_cnt + 1'b1;
                    end
                end else begin
                    nxt_baud = baud_cnt + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shreg <= fifo_rd;
        end else if (shift_en) begin
            shreg <= shreg >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (pop) par_q <= (^fifo_rd) ^ PARITY_ODD;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: decodes the serial line and compares against a frame/queue model.
module tb_uart_tx_fifo;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] a_data;
    logic       a_valid, a_ready, a_tx, a_busy;
    logic [4:0] a_count;
    logic [6:0] b_data;
    logic       b_valid, b_ready, b_tx, b_busy;
    logic [2:0] b_count;
`ifdef UART_TX_PARITY_EN
    logic [7:0] p0_data, p1_data;
    logic       p0_valid, p0_ready, p0_tx, p0_busy;
    logic       p1_valid, p1_ready, p1_tx, p1_busy;
    logic [4:0] p0_count, p1_count;
`endif

    logic [15:0] got_bits [4][32];
    int          got_t    [4][32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_W(8), .FIFO_DEPTH(16), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
        .tx_data(a_tx), .busy(a_busy), .fifo_count(a_count));

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_W(7), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .tx_data(b_tx), .busy(b_busy), .fifo_count(b_count));

`ifdef UART_TX_PARITY_EN
    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_W(8), .FIFO_DEPTH(16), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut_p0 (
        .clk(clk), .rst(rst), .s_data(p0_data), .s_valid(p0_valid), .s_ready(p0_ready),
        .tx_data(p0_tx), .busy(p0_busy), .fifo_count(p0_count));

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_W(8), .FIFO_DEPTH(16), .STOP_BITS(1), .PARITY_ODD(1'b1)) dut_p1 (
        .clk(clk), .rst(rst), .s_data(p1_data), .s_valid(p1_valid), .s_ready(p1_ready),
        .tx_data(p1_tx), .busy(p1_busy), .fifo_count(p1_count));
`endif

    // Expected line bits: start 0, data LSB first, optional parity, then everything high.
    function automatic logic [15:0] frame_model(input int dw, input bit par_en, input bit odd, input logic [8:0] d);
        logic [15:0] f;
        int pos, ones;
        f = '1; f[0] = 1'b0; pos = 1; ones = 0;
        for (int i = 0; i < dw; i++) begin
            f[pos] = d[i]; ones += int'(d[i]); pos++;
        end
        if (par_en) f[pos] = ((ones % 2) == 1) ^ odd;
        return f;
    endfunction

    function automatic logic tx_of(input int sel);
        case (sel)
            0: return a_tx;
            1: return b_tx;
`ifdef UART_TX_PARITY_EN
            2: return p0_tx;
            3: return p1_tx;
`endif
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0: return a_ready;
            1: return b_ready;
`ifdef UART_TX_PARITY_EN
            2: return p0_ready;
            3: return p1_ready;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input int sel, input logic [8:0] d, input logic v);
        case (sel)
            0: begin a_data = d[7:0]; a_valid = v; end
            1: begin b_data = d[6:0]; b_valid = v; end
`ifdef UART_TX_PARITY_EN
            2: begin p0_data = d[7:0]; p0_valid = v; end
            3: begin p1_data = d[7:0]; p1_valid = v; end
`endif
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with s_valid still high.
    task automatic push(input int sel, input logic [8:0] d);
        int g;
        g = 0;
        drive(sel, d, 1'b1);
        while (!ready_of(sel) && g < 20000) begin @(negedge clk); g++; end
        if (g >= 20000) begin
            n_checks++; n_errors++;
            $display("FAIL push_timeout sel=%0d got=ready_low exp=ready_high", sel);
        end
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic decode_frame(input int sel, input int nbits, output logic [15:0] bits, output int t0, output bit found);
        int g;
        g = 0; bits = '1; t0 = 0; found = 1'b0;
        while (tx_of(sel) !== 1'b0 && g < 20000) begin @(negedge clk); g++; end
        if (g >= 20000) return;
        found = 1'b1; t0 = cyc;
        for (int k = 0; k < nbits; k++) begin
            wait_cyc(t0 + DIV * k + DIV / 2);
            bits[k] = tx_of(sel);
        end
    endtask

    task automatic decode_n(input int sel, input int n, input int nbits);
        bit found;
        for (int i = 0; i < n; i++) begin
            decode_frame(sel, nbits, got_bits[sel][i], got_t[sel][i], found);
            if (!found) begin
                n_checks++; n_errors++;
                $display("FAIL frame_timeout sel=%0d got=%0d frames exp=%0d", sel, i, n);
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(0, 9'h0, 1'b0); drive(1, 9'h0, 1'b0);
`ifdef UART_TX_PARITY_EN
        drive(2, 9'h0, 1'b0); drive(3, 9'h0, 1'b0);
`endif
        repeat (3) @(negedge clk);
        n_checks++; if (a_tx !== 1'b1)    begin n_errors++; $display("FAIL reset_a_tx got=%b exp=1", a_tx); end
        n_checks++; if (a_busy !== 1'b0)  begin n_errors++; $display("FAIL reset_a_busy got=%b exp=0", a_busy); end
        n_checks++; if (a_count !== 5'd0) begin n_errors++; $display("FAIL reset_a_count got=%0d exp=0", a_count); end
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
        n_checks++; if ({b_tx, b_busy, b_count, b_ready} !== {1'b1, 1'b0, 3'd0, 1'b1})
            begin n_errors++; $display("FAIL reset_b got=%b%b%0d%b exp=1001", b_tx, b_busy, b_count, b_ready); end
`ifdef UART_TX_PARITY_EN
        n_checks++; if ({p0_tx, p0_busy, p0_count, p0_ready, p1_tx, p1_busy, p1_count, p1_ready} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1})
            begin n_errors++; $display("FAIL reset_parity_duts got=%b%b exp=11", p0_tx, p1_tx); end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte;
        int t_n;
        logic [15:0] exp;
        exp = frame_model(8, 1'b0, 1'b0, 9'h0A5);
        push(0, 9'h0A5);
        drive(0, 9'h0, 1'b0);
        t_n = cyc;
        n_checks++; if (a_count !== 5'd1) begin n_errors++; $display("FAIL single_count_accept got=%0d exp=1", a_count); end
        n_checks++; if (a_busy !== 1'b1)  begin n_errors++; $display("FAIL single_busy_accept got=%b exp=1", a_busy); end
        @(negedge clk);
        n_checks++; if ({a_count, a_tx} !== {5'd0, 1'b1}) begin n_errors++; $display("FAIL single_pop got=%0d/%b exp=0/1", a_count, a_tx); end
        @(negedge clk);
        n_checks++; if (a_tx !== 1'b0) begin n_errors++; $display("FAIL single_start_latency got=%b exp=0", a_tx); end
        for (int k = 0; k < 10; k++) begin
            wait_cyc(t_n + 2 + DIV * k + DIV / 2);
            n_checks++;
            if (a_tx !== exp[k]) begin n_errors++; $display("FAIL single_bit%0d got=%b exp=%b", k, a_tx, exp[k]); end
        end
        wait_cyc(t_n + 100);
        n_checks++; if (a_busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_stop got=%b exp=1", a_busy); end
        wait_cyc(t_n + 101);
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_end got=%b exp=0", a_busy); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] base;
        bit full_seen, ready_bad, done;
        base = 8'($urandom);
        full_seen = 1'b0; ready_bad = 1'b0; done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) push(0, {1'b0, base + 8'(i)});
                drive(0, 9'h0, 1'b0);
            end
            begin decode_n(0, 20, 10); done = 1'b1; end
            begin
                int g;
                g = 0;
                while (!done && g < 5000) begin
                    @(negedge clk); g++;
                    if (a_count == 5'd16) begin
                        full_seen = 1'b1;
                        if (a_ready !== 1'b0) ready_bad = 1'b1;
                    end
                end
            end
        join
        n_checks++; if (full_seen !== 1'b1) begin n_errors++; $display("FAIL burst_reached_full got=%b exp=1", full_seen); end
        n_checks++; if (ready_bad !== 1'b0) begin n_errors++; $display("FAIL burst_ready_when_full got=%b exp=0", ready_bad); end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (got_bits[0][i] !== frame_model(8, 1'b0, 1'b0, {1'b0, base + 8'(i)}))
                begin n_errors++; $display("FAIL burst_frame%0d got=%h exp=%h", i, got_bits[0][i], frame_model(8, 1'b0, 1'b0, {1'b0, base + 8'(i)})); end
            if (i > 0) begin
                n_checks++;
                if (got_t[0][i] - got_t[0][i-1] != 10 * DIV)
                    begin n_errors++; $display("FAIL burst_gap%0d got=%0d exp=%0d", i, got_t[0][i] - got_t[0][i-1], 10 * DIV); end
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_push_pop;
        logic [7:0] w [5];
        int t_n;
        for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
        fork
            decode_n(0, 5, 10);
            begin
                push(0, {1'b0, w[0]});
                t_n = cyc;
                for (int i = 1; i < 4; i++) push(0, {1'b0, w[i]});
                drive(0, 9'h0, 1'b0);
                n_checks++; if (a_count !== 5'd3) begin n_errors++; $display("FAIL pp_fill got=%0d exp=3", a_count); end
                wait_cyc(t_n + 100);
                n_checks++; if (a_count !== 5'd3) begin n_errors++; $display("FAIL pp_before got=%0d exp=3", a_count); end
                drive(0, {1'b0, w[4]}, 1'b1);
                @(negedge clk);
                drive(0, 9'h0, 1'b0);
                n_checks++; if (a_count !== 5'd3) begin n_errors++; $display("FAIL pp_same_edge got=%0d exp=3", a_count); end
                @(negedge clk);
                n_checks++; if (a_count !== 5'd3) begin n_errors++; $display("FAIL pp_after got=%0d exp=3", a_count); end
            end
        join
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (got_bits[0][i] !== frame_model(8, 1'b0, 1'b0, {1'b0, w[i]}))
                begin n_errors++; $display("FAIL pp_frame%0d got=%h exp=%h", i, got_bits[0][i], frame_model(8, 1'b0, 1'b0, {1'b0, w[i]})); end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d0;
        logic [15:0] e0, bits;
        int t_n, t2, t0;
        bit found;
        d0 = 8'($urandom);
        e0 = frame_model(8, 1'b0, 1'b0, {1'b0, d0});
        push(0, {1'b0, d0});
        t_n = cyc;
        push(0, 9'($urandom & 8'hFF));
        push(0, 9'($urandom & 8'hFF));
        drive(0, 9'h0, 1'b0);
        wait_cyc(t_n + 2 + 5 * DIV + 4);
        n_checks++; if (a_tx !== e0[5]) begin n_errors++; $display("FAIL rst_in_bit4 got=%b exp=%b", a_tx, e0[5]); end
        rst = 1'b0;
        #1;
        n_checks++; if (a_tx !== 1'b1)    begin n_errors++; $display("FAIL rst_mid_tx got=%b exp=1", a_tx); end
        n_checks++; if (a_count !== 5'd0) begin n_errors++; $display("FAIL rst_mid_count got=%0d exp=0", a_count); end
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_ready got=%b exp=1", a_ready); end
        n_checks++; if (a_busy !== 1'b0)  begin n_errors++; $display("FAIL rst_mid_busy got=%b exp=0", a_busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push(0, 9'h03C);
        drive(0, 9'h0, 1'b0);
        t2 = cyc;
        decode_frame(0, 10, bits, t0, found);
        n_checks++; if (t0 !== t2 + 2) begin n_errors++; $display("FAIL rst_after_latency got=%0d exp=%0d", t0, t2 + 2); end
        n_checks++; if (bits !== frame_model(8, 1'b0, 1'b0, 9'h03C)) begin n_errors++; $display("FAIL rst_after_frame got=%h exp=%h", bits, frame_model(8, 1'b0, 1'b0, 9'h03C)); end
        wait_cyc(t0 + 10 * DIV + 20);
        n_checks++; if ({a_busy, a_count, a_tx} !== {1'b0, 5'd0, 1'b1}) begin n_errors++; $display("FAIL rst_after_idle got=%b/%0d/%b exp=0/0/1", a_busy, a_count, a_tx); end
    endtask

    task automatic test_two_stop;
        logic [6:0] r;
        r = 7'($urandom);
        fork
            begin push(1, 9'h055); push(1, {2'b0, r}); drive(1, 9'h0, 1'b0); end
            decode_n(1, 2, 10);
        join
        n_checks++; if (got_bits[1][0] !== frame_model(7, 1'b0, 1'b0, 9'h055)) begin n_errors++; $display("FAIL stop2_frame0 got=%h exp=%h", got_bits[1][0], frame_model(7, 1'b0, 1'b0, 9'h055)); end
        n_checks++; if (got_bits[1][1] !== frame_model(7, 1'b0, 1'b0, {2'b0, r})) begin n_errors++; $display("FAIL stop2_frame1 got=%h exp=%h", got_bits[1][1], frame_model(7, 1'b0, 1'b0, {2'b0, r})); end
        n_checks++; if (got_t[1][1] - (got_t[1][0] + 8 * DIV) != 20) begin n_errors++; $display("FAIL stop2_next_start got=%0d exp=20", got_t[1][1] - (got_t[1][0] + 8 * DIV)); end
        wait_cyc(got_t[1][1] + 10 * DIV + 5);
        n_checks++; if (b_busy !== 1'b0) begin n_errors++; $display("FAIL stop2_busy_end got=%b exp=0", b_busy); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] r0, r1;
        r0 = 8'($urandom); r1 = 8'($urandom);
        fork
            begin push(2, 9'h007); push(2, {1'b0, r0}); drive(2, 9'h0, 1'b0); end
            begin push(3, 9'h007); push(3, {1'b0, r1}); drive(3, 9'h0, 1'b0); end
            decode_n(2, 2, 11);
            decode_n(3, 2, 11);
        join
        n_checks++; if (got_bits[2][0][9] !== 1'b1) begin n_errors++; $display("FAIL par_even_07 got=%b exp=1", got_bits[2][0][9]); end
        n_checks++; if (got_bits[3][0][9] !== 1'b0) begin n_errors++; $display("FAIL par_odd_07 got=%b exp=0", got_bits[3][0][9]); end
        n_checks++; if (got_bits[2][1] !== frame_model(8, 1'b1, 1'b0, {1'b0, r0})) begin n_errors++; $display("FAIL par_even_rand got=%h exp=%h", got_bits[2][1], frame_model(8, 1'b1, 1'b0, {1'b0, r0})); end
        n_checks++; if (got_bits[3][1] !== frame_model(8, 1'b1, 1'b1, {1'b0, r1})) begin n_errors++; $display("FAIL par_odd_rand got=%h exp=%h", got_bits[3][1], frame_model(8, 1'b1, 1'b1, {1'b0, r1})); end
        n_checks++; if (got_t[2][1] - got_t[2][0] != 11 * DIV) begin n_errors++; $display("FAIL par_frame_len got=%0d exp=%0d", got_t[2][1] - got_t[2][0], 11 * DIV); end
    endtask
`endif

    task automatic test_random;
        logic [7:0] exp_q [$];
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    exp_q.push_back(d);
                    push(0, {1'b0, d});
                    drive(0, 9'h0, 1'b0);
                    repeat ($urandom_range(0, 150)) @(negedge clk);
                end
            end
            decode_n(0, 25, 10);
        join
        for (int i = 0; i < 25; i++) begin
            n_checks++;
            if (got_bits[0][i] !== frame_model(8, 1'b0, 1'b0, {1'b0, exp_q[i]}))
                begin n_errors++; $display("FAIL rand_frame%0d got=%h exp=%h", i, got_bits[0][i], frame_model(8, 1'b0, 1'b0, {1'b0, exp_q[i]})); end
        end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_push_pop;
        test_reset_mid_frame;
        test_two_stop;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
